// File: rtl/dma_priority_ctrl.sv
// DMA priority controller: synchronizes per-channel requests, picks a winner
// (fixed or rotating priority), negotiates the bus with the CPU via HRQ/HLDA,
// and acknowledges the granted channel until its transfer terminates.
//
// Handshake: HRQ is raised when a winner is latched and stays high until the
// service ends; the CPU answers with HLDA. DACK is driven only in SERVE, which
// is entered or held only on an edge where HLDA=1 was sampled. Once in SERVE,
// a sampled XFER_DONE, EOP or HLDA=0 ends the service, and RELEASE drops HRQ
// and waits for HLDA=0 before returning to IDLE.
//
// dbg_state encoding: 0 = IDLE, 1 = WAIT_HLDA, 2 = SERVE, 3 = RELEASE.
module dma_priority_ctrl #(
  parameter int NCH = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [NCH-1:0] DREQ,
  input  logic [NCH-1:0] MASK,
  input  logic           ROTATE,
  input  logic           HLDA,
  input  logic           XFER_DONE,
  input  logic           EOP,
  output logic           HRQ,
  output logic [NCH-1:0] DACK,
  output logic [1:0]     CH_SEL,
  output logic           BUSY,
  output logic [1:0]     dbg_state,
  output logic [1:0]     dbg_last_served
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HLDA = 2'd1,
    SERVE     = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [NCH-1:0] sreq_meta;
  logic [NCH-1:0] sreq;
  logic [NCH-1:0] eff_req;
  logic [1:0]     latched_ch;
  logic [1:0]     last_served;
  logic [1:0]     prio_start;
  logic [1:0]     prio_idx;
  logic [1:0]     winner;
  logic           winner_found;
  logic           serve_exit;

  // Two-flop synchronizer for the asynchronous request lines
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sreq_meta <= '0;
      sreq      <= '0;
    end else begin
      sreq_meta <= DREQ;
      sreq      <= sreq_meta;
    end
  end

  assign eff_req = sreq & ~MASK;

  // Priority search: scan four channels starting at 0 (fixed) or last_served+1 (rotating)
  always_comb begin
    prio_start   = ROTATE ? (last_served + 2'd1) : 2'd0;
    prio_idx     = 2'd0;
    winner       = 2'd0;
    winner_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      prio_idx = prio_start + 2'(k);
      if (!winner_found && eff_req[prio_idx]) begin
        winner       = prio_idx;
        winner_found = 1'b1;
      end
    end
  end

  // Any exit from SERVE (termination or lost HLDA) ends the service
  assign serve_exit = (state == SERVE) && (!HLDA || XFER_DONE || EOP);

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; XFER_DONE/EOP are only looked at in SERVE
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (|eff_req) next_state = WAIT_HLDA;
      WAIT_HLDA: if (HLDA)     next_state = SERVE;
      SERVE:     if (serve_exit) next_state = RELEASE;
      RELEASE:   if (!HLDA)    next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Winner is captured once in IDLE and held until the next return to IDLE
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      latched_ch <= 2'd0;
    end else if (state == IDLE && winner_found) begin
      latched_ch <= winner;
    end
  end

  // Rotation pointer advances to the served channel when SERVE is left
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last_served <= 2'd3;
    end else if (serve_exit) begin
      last_served <= latched_ch;
    end
  end

  // Outputs decoded from state only, so reset clears them immediately
  always_comb begin
    HRQ    = 1'b0;
    DACK   = '0;
    CH_SEL = 2'd0;
    BUSY   = (state != IDLE);
    case (state)
      WAIT_HLDA: begin
        HRQ    = 1'b1;
        CH_SEL = latched_ch;
      end
      SERVE: begin
        HRQ    = 1'b1;
        DACK   = {{(NCH-1){1'b0}}, 1'b1} << latched_ch;
        CH_SEL = latched_ch;
      end
      default: begin
        HRQ    = 1'b0;
      end
    endcase
  end

  assign dbg_state       = state;
  assign dbg_last_served = last_served;

endmodule

// File: tb/tb_dma_priority_ctrl.sv
// Bench for dma_priority_ctrl: directed scenarios for the documented cases,
// then randomized traffic, all compared against a behavioural model.
module tb_dma_priority_ctrl;

  localparam int NCH = 4;
  localparam int S_IDLE = 0, S_WAIT = 1, S_SERVE = 2, S_REL = 3;

  logic           CLK;
  logic           RESET;
  logic [NCH-1:0] DREQ;
  logic [NCH-1:0] MASK;
  logic           ROTATE;
  logic           HLDA;
  logic           XFER_DONE;
  logic           EOP;
  logic           HRQ;
  logic [NCH-1:0] DACK;
  logic [1:0]     CH_SEL;
  logic           BUSY;
  logic [1:0]     dbg_state;
  logic [1:0]     dbg_last_served;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  logic [NCH-1:0] exp_q[$];

  dma_priority_ctrl #(.NCH(NCH)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .MASK(MASK), .ROTATE(ROTATE),
    .HLDA(HLDA), .XFER_DONE(XFER_DONE), .EOP(EOP), .HRQ(HRQ), .DACK(DACK),
    .CH_SEL(CH_SEL), .BUSY(BUSY), .dbg_state(dbg_state),
    .dbg_last_served(dbg_last_served)
  );

  // clock / reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Requests reach the arbiter two edges after they are sampled, modelled as
  // a history queue of raw DREQ samples.
  logic [NCH-1:0] hist[$];
  int             ph          = S_IDLE;
  int             m_ch        = 0;
  int             m_last      = 3;
  bit             m_prev_hlda = 0;

  task automatic model_reset();
    hist.delete();
    ph          = S_IDLE;
    m_ch        = 0;
    m_last      = 3;
    m_prev_hlda = 0;
  endtask

  task automatic model_step();
    logic [NCH-1:0] eff;
    int  start;
    bit  found;
    eff   = (hist.size() == 2) ? (hist[0] & ~MASK) : '0;
    found = 0;
    case (ph)
      S_IDLE: begin
        if (eff != 0) begin
          start = ROTATE ? (m_last + 1) % 4 : 0;
          for (int k = 0; k < 4; k++) begin
            int c;
            c = (start + k) % 4;
            if (!found && eff[c]) begin
              m_ch  = c;
              found = 1;
            end
          end
          ph = S_WAIT;
        end
      end
      S_WAIT:  if (HLDA) ph = S_SERVE;
      S_SERVE: if (!HLDA || XFER_DONE || EOP) begin
        m_last = m_ch;
        ph     = S_REL;
      end
      default: if (!HLDA) ph = S_IDLE;
    endcase
    m_prev_hlda = HLDA;
    hist.push_back(DREQ);
    if (hist.size() > 2) void'(hist.pop_front());
  endtask

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) model_reset();
    else        model_step();
  end

  // scoreboard compare of every output each cycle, away from the active edge
  always @(negedge CLK) begin
    if (chk_en) begin
      check("hrq",   HRQ,  (ph == S_WAIT || ph == S_SERVE));
      check("dack",  DACK, (ph == S_SERVE) ? (32'd1 << m_ch) : 32'd0);
      check("ch_sel", CH_SEL, (ph == S_WAIT || ph == S_SERVE) ? m_ch : 0);
      check("busy",  BUSY, (ph != S_IDLE));
      check("state", dbg_state, ph);
      check("last_served", dbg_last_served, m_last);
      check("dack_onehot", $onehot0(DACK), 1);
      if (!m_prev_hlda) check("dack_after_hlda_low", DACK, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_hrq(input string tag);
    int n;
    n = 0;
    while (!HRQ && n < 20) begin
      tick();
      n++;
    end
    if (!HRQ) check(tag, 0, 1);
  endtask

  task automatic wait_dack(input string tag);
    int n;
    n = 0;
    while (DACK == 0 && n < 20) begin
      tick();
      n++;
    end
    if (DACK == 0) check(tag, 0, 1);
  endtask

  task automatic apply_reset();
    #2 RESET = 1'b0;
    HLDA = 0; XFER_DONE = 0; EOP = 0; DREQ = 0;
    tick();
    tick();
    RESET = 1'b1;
    tick();
  endtask

  // end a service cleanly: requests cleared with the terminating pulse
  task automatic finish_service();
    DREQ      = '0;
    XFER_DONE = 1'b1;
    tick();
    XFER_DONE = 1'b0;
    HLDA      = 1'b0;
    tick();
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    RESET = 1'b1; DREQ = '0; MASK = '0; ROTATE = 0;
    HLDA = 0; XFER_DONE = 0; EOP = 0;
    #2 RESET = 1'b0;
    #1 chk_en = 1;
    // reset state
    check("rst_hrq", HRQ, 0);
    check("rst_dack", DACK, 0);
    check("rst_chsel", CH_SEL, 0);
    check("rst_busy", BUSY, 0);
    check("rst_last", dbg_last_served, 3);
    tick();
    tick();
    RESET = 1'b1;
    tick();

    // fixed priority, two requesters: HRQ 3 edges later, ch1 wins
    ROTATE = 0; MASK = '0; DREQ = 4'b0110;
    n = 0;
    do begin
      tick();
      n++;
    end while (!HRQ && n < 10);
    check("hrq_latency", n, 3);
    HLDA = 1;
    tick();
    check("fixed_dack", DACK, 4'b0010);
    check("fixed_chsel", CH_SEL, 1);
    finish_service();

    // masked request is ignored; unmasking raises HRQ on the next edge
    MASK = 4'b0001; DREQ = 4'b0001;
    repeat (5) begin
      tick();
      check("masked_hrq", HRQ, 0);
    end
    MASK = 4'b0000;
    tick();
    check("unmask_hrq", HRQ, 1);
    HLDA = 1;
    wait_dack("unmask_dack_timeout");
    finish_service();

    // rotating priority with all channels requesting
    apply_reset();
    ROTATE = 1; DREQ = 4'b1111;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    while (exp_q.size() > 0) begin
      wait_hrq("rot_hrq_timeout");
      HLDA = 1;
      wait_dack("rot_dack_timeout");
      check("rot_dack_seq", DACK, exp_q.pop_front());
      if (exp_q.size() == 0) DREQ = '0;
      XFER_DONE = 1;
      tick();
      XFER_DONE = 0;
      HLDA = 0;
    end
    tick();
    tick();

    // simultaneous EOP and XFER_DONE on ch2: a single termination
    ROTATE = 0; DREQ = 4'b0100;
    wait_hrq("eop_hrq_timeout");
    check("eop_chsel", CH_SEL, 2);
    HLDA = 1;
    wait_dack("eop_dack_timeout");
    check("eop_dack", DACK, 4'b0100);
    DREQ = '0; EOP = 1; XFER_DONE = 1;
    tick();
    EOP = 0; XFER_DONE = 0;
    check("eop_state_rel", dbg_state, S_REL);
    check("eop_hrq", HRQ, 0);
    check("eop_dack0", DACK, 0);
    tick();
    check("eop_still_rel", dbg_state, S_REL);
    HLDA = 0;
    tick();
    check("eop_idle", dbg_state, S_IDLE);
    tick();

    // HLDA dropped in SERVE on ch1
    ROTATE = 1; DREQ = 4'b0010;
    wait_hrq("hlda_hrq_timeout");
    HLDA = 1;
    wait_dack("hlda_dack_timeout");
    check("hlda_last_before", dbg_last_served, 2);
    DREQ = '0; HLDA = 0;
    tick();
    check("hlda_drop_dack", DACK, 0);
    check("hlda_drop_state", dbg_state, S_REL);
    check("hlda_last_after", dbg_last_served, 1);
    tick();
    check("hlda_idle", dbg_state, S_IDLE);
    tick();

    // asynchronous reset during a service
    DREQ = 4'b0001;
    wait_hrq("arst_hrq_timeout");
    HLDA = 1;
    wait_dack("arst_dack_timeout");
    #3 RESET = 1'b0;
    #1;
    check("arst_hrq", HRQ, 0);
    check("arst_dack", DACK, 0);
    check("arst_busy", BUSY, 0);
    DREQ = '0; HLDA = 0;
    tick();
    tick();
    RESET = 1'b1;
    DREQ = 4'b1000; ROTATE = 1;
    wait_hrq("arst_req_timeout");
    check("arst_ch3_sel", CH_SEL, 3);
    HLDA = 1;
    wait_dack("arst_ch3_timeout");
    check("arst_ch3_dack", DACK, 4'b1000);
    finish_service();

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if ($urandom_range(0, 7) == 0) DREQ = 4'($urandom_range(0, 15));
      MASK = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      if ($urandom_range(0, 31) == 0) ROTATE = ~ROTATE;
      if (HRQ) HLDA = ($urandom_range(0, 15) != 0) ? (HLDA | ($urandom_range(0, 2) == 0)) : 1'b0;
      else     HLDA = HLDA & ($urandom_range(0, 2) != 0);
      XFER_DONE = ($urandom_range(0, 5) == 0);
      EOP       = ($urandom_range(0, 19) == 0);
      if (cyc % 1000 == 999) begin
        #3 RESET = 1'b0;
        @(posedge CLK);
        #1 RESET = 1'b1;
      end
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_priority_ctrl.md
DMA_PRIORITY_CTRL -- requirements
Module: dma_priority_ctrl

Interface
REQ-001 Parameter NCH, default 4: number of DMA request channels; only 4 is supported.
REQ-002 CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 DREQ  input  NCH  asynchronous per-channel DMA request lines, active-high.
REQ-005 MASK  input  NCH  per-channel mask bits; 1 = ignore that channel's DREQ.
REQ-006 ROTATE  input  1  priority mode: 0 = fixed (channel 0 highest), 1 = rotating.
REQ-007 HLDA  input  1  hold acknowledge from the CPU.
REQ-008 XFER_DONE  input  1  one-cycle pulse from timing control marking completion of the granted block transfer (terminal count).
REQ-009 EOP  input  1  external end-of-process, active-high; forces termination of the active service.
REQ-010 HRQ  output  1  hold request to the CPU.
REQ-011 DACK  output  NCH  one-hot acknowledge to the granted channel.
REQ-012 CH_SEL  output  2  binary index of the granted channel, used for datapath register-bank select.
REQ-013 BUSY  output  1  high in every state other than IDLE.

Function
REQ-014 Each DREQ bit SHALL pass through a two-flop synchronizer; only the synchronized value (sreq) SHALL be used.
REQ-015 The effective request vector SHALL be sreq AND NOT MASK.
REQ-016 The FSM SHALL have exactly four states: IDLE, WAIT_HLDA, SERVE and RELEASE.
REQ-017 IDLE: when the effective request is nonzero, the block SHALL latch the winning channel, assert HRQ and go to WAIT_HLDA on the same edge.
REQ-018 The winner SHALL be latched once in IDLE and SHALL NOT change until the FSM returns to IDLE; no preemption.
REQ-019 Fixed mode: lowest-numbered requesting channel wins.
REQ-020 Rotating mode: priority order SHALL start at (last_served+1) mod 4 and increment modulo 4, wrapping from 3 to 0.
REQ-021 last_served SHALL reset to 3, so channel 0 is highest after reset.
REQ-022 WAIT_HLDA: HRQ SHALL stay high; on HLDA=1 the FSM SHALL go to SERVE, with DACK one-hot on the latched channel from the next cycle.
REQ-023 If the latched channel's effective request drops before HLDA, the FSM SHALL still proceed to SERVE; the DACK is issued and timing control then terminates the service.
REQ-024 SERVE: HRQ and DACK SHALL stay high until XFER_DONE=1 or EOP=1 is sampled, then the FSM SHALL go to RELEASE.
REQ-025 When XFER_DONE and EOP are sampled high in the same cycle, the FSM SHALL treat it as a single termination.
REQ-026 On leaving SERVE, last_served SHALL be updated to the latched channel.
REQ-027 If HLDA drops during SERVE, DACK SHALL be deasserted in the next cycle and the FSM SHALL go to RELEASE.
REQ-028 RELEASE: HRQ=0 and DACK=0; the FSM SHALL wait for HLDA=0, then go to IDLE.
REQ-029 From IDLE, a pending request SHALL re-assert HRQ no earlier than one cycle after entering IDLE, giving a minimum of one HRQ-low cycle between services.
REQ-030 EOP or XFER_DONE sampled in IDLE, WAIT_HLDA or RELEASE SHALL be ignored.
REQ-031 CH_SEL SHALL equal the latched channel in WAIT_HLDA and SERVE, and SHALL be 0 otherwise.
REQ-032 DACK SHALL never have more than one bit set, and SHALL be all-zero whenever HLDA=0 was sampled in the previous cycle.

Reset
REQ-033 While RESET=0 the block SHALL hold HRQ=0, DACK=0, CH_SEL=0, BUSY=0, state IDLE, last_served=3 and synchronizers cleared.
REQ-034 Reset SHALL take effect asynchronously, including in the middle of a service, with outputs cleared without waiting for a clock edge.
REQ-035 After RESET rises, the block SHALL resume from IDLE, and synchronized requests SHALL take 2 cycles to appear.

Verification
REQ-036 ROTATE=0, MASK=0, DREQ=4'b0110 -> HRQ high 3 edges after DREQ; HLDA=1 -> DACK=4'b0010 and CH_SEL=1 on the next cycle.
REQ-037 ROTATE=1, DREQ=4'b1111 held, XFER_DONE each service, HLDA echoing HRQ -> DACK sequence 0001, 0010, 0100, 1000, 0001.
REQ-038 DREQ=4'b0001 with MASK=4'b0001 -> HRQ stays 0; clearing MASK -> HRQ rises on the next edge.
REQ-039 In SERVE on ch2, pulse EOP and XFER_DONE together -> exactly one transition to RELEASE, HRQ=0 and DACK=0; IDLE after HLDA falls.
REQ-040 In SERVE, drive RESET=0 between clock edges -> HRQ, DACK and BUSY go 0 immediately; after release, DREQ=4'b1000 with ROTATE=1 -> ch3 granted.
REQ-041 In SERVE, drop HLDA -> DACK=0 next cycle, state RELEASE, no update to last_served before leaving SERVE.
